hll_harmonic_sum: RTL and testbench

//  Producer side of the reciprocal divider. Scans the HLL rank-register bank once per start request.

---
 rtl/hll_harmonic_sum.sv | 115 +++++++++++
 tb/tb_hll_harmonic_sum.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hll_harmonic_sum.sv
// hll_harmonic_sum: scans the HLL rank-register bank once per start and
// produces the fixed-point harmonic sum S = sum_j 2^-M[j] plus the count of
// zero registers, presented as a one-cycle valid/data pulse for newton_div.
module hll_harmonic_sum #(
  parameter int NUM_REGS   = 1024,
  parameter int RANK_W     = 5,
  parameter int FRAC_BITS  = 21,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        rd_en,
  output logic [$clog2(NUM_REGS)-1:0] rd_addr,
  input  logic [RANK_W-1:0]           rd_data,
  output logic                        sum_valid,
  output logic [31:0]                 sum_value,
  output logic [$clog2(NUM_REGS):0]   zero_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int ZW = AW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [AW-1:0]           addr_q;
  logic [2:0]              drain_cnt;
  logic [RD_LATENCY-1:0]   vld_sr;
  logic [31:0]             acc;
  logic [ZW-1:0]           zc;
  logic [31:0]             rank_ext;
  logic [31:0]             term;
  logic [32:0]             sum_w;

  assign rd_en     = (state == SCAN);
  assign busy      = (state != IDLE);
  assign sum_valid = (state == DONE);
  assign rd_addr   = addr_q;

  // Per-datum term 2^(FRAC_BITS - rank); ranks beyond FRAC_BITS contribute nothing
  always_comb begin
    rank_ext = 32'(rd_data);
    term     = '0;
    if (rank_ext <= 32'(FRAC_BITS))
      term = 32'd1 << (32'(FRAC_BITS) - rank_ext);
    sum_w = {1'b0, acc} + {1'b0, term};
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SCAN;
      SCAN:    if (addr_q == AW'(NUM_REGS - 1)) state_nx = DRAIN;
      // DRAIN lasts RD_LATENCY+1 cycles: RD_LATENCY for the last datum to
      // arrive and one more for it to settle into acc before it is latched.
      DRAIN:   if (drain_cnt == 3'(RD_LATENCY)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, read address and drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start)
        addr_q <= '0;
      else if (state == SCAN)
        addr_q <= addr_q + 1'b1;
      if (state == DRAIN)
        drain_cnt <= drain_cnt + 1'b1;
      else
        drain_cnt <= '0;
    end
  end

  // Read-valid tracking: bit RD_LATENCY-1 marks a cycle carrying valid rd_data
  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= RD_LATENCY'({vld_sr, rd_en});
  end

  // Saturating harmonic-sum accumulator and zero counter
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      zc  <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      zc  <= '0;
    end else if (vld_sr[RD_LATENCY-1]) begin
      acc <= sum_w[32] ? '1 : sum_w[31:0];
      zc  <= zc + ZW'(rd_data == '0);
    end
  end

  // Result registers, loaded as DONE is entered and held until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_value  <= '0;
      zero_count <= '0;
    end else if (state == DRAIN && state_nx == DONE) begin
      sum_value  <= (acc == '0) ? 32'd1 : acc;
      zero_count <= zc;
    end
  end

endmodule

// File: tb/tb_hll_harmonic_sum.sv
// Directed bench for hll_harmonic_sum: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=3, both NUM_REGS=64, each fed by a behavioural bank model.
module tb_hll_harmonic_sum;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  bit         sel = 1'b0;   // 0: latency-1 instance, 1: latency-3 instance

  logic [4:0] mem [N];

  logic       start_a, start_b;
  logic       busy_a, busy_b, rd_en_a, rd_en_b, sv_a, sv_b;
  logic [5:0] addr_a, addr_b;
  logic [4:0] data_a, data_b;
  logic [31:0] val_a, val_b;
  logic [6:0] zc_a, zc_b;
  logic [4:0] p1_a, p1_b, p2_b, p3_b;

  logic       busy_s, rd_en_s, sv_s;
  logic [5:0] addr_s;
  logic [31:0] val_s;
  logic [6:0] zc_s;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  hll_harmonic_sum #(.NUM_REGS(N), .RANK_W(5), .FRAC_BITS(21), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .rd_en(rd_en_a),
    .rd_addr(addr_a), .rd_data(data_a), .sum_valid(sv_a), .sum_value(val_a),
    .zero_count(zc_a));

  hll_harmonic_sum #(.NUM_REGS(N), .RANK_W(5), .FRAC_BITS(21), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .rd_en(rd_en_b),
    .rd_addr(addr_b), .rd_data(data_b), .sum_valid(sv_b), .sum_value(val_b),
    .zero_count(zc_b));

  // Bank models; cycles without a read return 0, whose large term would
  // expose any accumulation of unmarked data.
  always @(posedge clk) begin
    p1_a <= rd_en_a ? mem[addr_a] : 5'd0;
    p1_b <= rd_en_b ? mem[addr_b] : 5'd0;
    p2_b <= p1_b;
    p3_b <= p2_b;
  end
  assign data_a = p1_a;
  assign data_b = p3_b;

  assign busy_s  = sel ? busy_b  : busy_a;
  assign rd_en_s = sel ? rd_en_b : rd_en_a;
  assign sv_s    = sel ? sv_b    : sv_a;
  assign addr_s  = sel ? addr_b  : addr_a;
  assign val_s   = sel ? val_b   : val_a;
  assign zc_s    = sel ? zc_b    : zc_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < N; j++)
      case (mode)
        0: mem[j] = 5'd0;
        1: mem[j] = 5'd1;
        2: mem[j] = 5'd2;
        3: mem[j] = 5'(j % 4);
        default: mem[j] = 5'd31;
      endcase
  endtask

  // One full scan; n counts cycles after the cycle in which start is sampled.
  task automatic run_scan(input string tag, input logic [31:0] exp_sum,
                          input int exp_zc, input int exp_lat, input bit inject);
    int n_en = 0, first_en = -1, last_en = -1, addr_bad = 0, n_sv = 0, sv_at = -1;
    logic [31:0] sv_val = '0;
    logic [6:0]  sv_zc = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= exp_lat + 12; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en_s) begin
        if (first_en < 0) first_en = n;
        last_en = n;
        if (int'(addr_s) != n_en) addr_bad++;
        n_en++;
      end
      if (sv_s) begin
        n_sv++;
        if (sv_at < 0) begin
          sv_at  = n;
          sv_val = val_s;
          sv_zc  = zc_s;
        end
      end
      if (inject && (n == 30 || sv_s)) start = 1'b1;
    end
    check({tag, " first_rd_en"}, 64'(first_en), 64'd1);
    check({tag, " rd_en_count"}, 64'(n_en), 64'(N));
    check({tag, " addr_seq_errors"}, 64'(addr_bad), 64'd0);
    check({tag, " sv_latency"}, 64'(sv_at), 64'(exp_lat));
    check({tag, " sv_after_last_rd"}, 64'(sv_at - last_en), 64'(exp_lat - N));
    check({tag, " sv_pulses"}, 64'(n_sv), 64'd1);
    check({tag, " sum_value"}, 64'(sv_val), 64'(exp_sum));
    check({tag, " zero_count"}, 64'(sv_zc), 64'(exp_zc));
    check({tag, " sum_held"}, 64'(val_s), 64'(exp_sum));
    check({tag, " busy_after"}, 64'(busy_s), 64'd0);
  endtask

  initial begin
    int n_sv, n_en, k;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset rd_en", 64'(rd_en_a), 64'd0);
    check("reset rd_addr", 64'(addr_a), 64'd0);
    check("reset sum_valid", 64'(sv_a), 64'd0);
    check("reset sum_value", 64'(val_a), 64'd0);
    check("reset zero_count", 64'(zc_a), 64'd0);

    fill(0); run_scan("all0", 32'h0800_0000, 64, 67, 1'b0);
    fill(1); run_scan("all1", 32'h0400_0000, 0, 67, 1'b0);
    fill(3); run_scan("mod4", 32'h03C0_0000, 16, 67, 1'b0);
    fill(4); run_scan("all31", 32'h0000_0001, 0, 67, 1'b0);
    fill(0); run_scan("restart_ignored", 32'h0800_0000, 64, 67, 1'b1);

    // Reset at scan address 20, with start held alongside it
    fill(1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    k = 0;
    while (addr_a != 6'd20 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("mid reached addr20", 64'(addr_a), 64'd20);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("midrst busy", 64'(busy_a), 64'd0);
    check("midrst rd_en", 64'(rd_en_a), 64'd0);
    check("midrst rd_addr", 64'(addr_a), 64'd0);
    check("midrst sum_valid", 64'(sv_a), 64'd0);
    check("midrst sum_value", 64'(val_a), 64'd0);
    check("midrst zero_count", 64'(zc_a), 64'd0);
    n_sv = 0;
    n_en = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sv_a) n_sv++;
      if (rd_en_a) n_en++;
    end
    check("midrst no sum_valid", 64'(n_sv), 64'd0);
    check("midrst no reads", 64'(n_en), 64'd0);
    run_scan("after_rst", 32'h0400_0000, 0, 67, 1'b0);

    // Longer read latency
    sel = 1'b1;
    fill(2);
    run_scan("lat3_all2", 32'h0200_0000, 0, 69, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
